voice_phase_sweeper: RTL and testbench

//  Per-sample phase-accumulator engine for the polyphonic oscillator bank. Owns port A of a

---
 rtl/voice_phase_sweeper_pkg.sv | 15 +
 rtl/voice_phase_sweeper.sv | 115 +++++++++++
 tb/tb_voice_phase_sweeper.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_phase_sweeper_pkg.sv
// Shared sizing and state encoding for the oscillator-bank phase sweeper.
package voice_phase_sweeper_pkg;

  localparam int unsigned NUM_VOICES  = 16;
  localparam int unsigned VOICE_BITS  = 4;
  localparam int unsigned PHASE_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/voice_phase_sweeper.sv
// Per-sample phase accumulator: zeroes the phase RAM after reset, then on each
// sample_tick reads, advances and writes back every voice's phase over port A.
module voice_phase_sweeper
  import voice_phase_sweeper_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  output logic [VOICE_BITS-1:0]  ram_addr,
  output logic                   ram_we,
  output logic [PHASE_WIDTH-1:0] ram_wdata,
  input  logic [PHASE_WIDTH-1:0] ram_rdata,
  output logic [VOICE_BITS-1:0]  inc_addr,
  input  logic [PHASE_WIDTH-1:0] inc_data,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [VOICE_BITS-1:0]  voice_out,
  output logic                   phase_valid,
  output logic                   sweep_done,
  output logic                   busy,
  output logic [VOICE_BITS-1:0]  busy_voice,
  output logic                   init_done,
  output logic                   overrun
);

  localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic [VOICE_BITS-1:0] ONE_VOICE  = VOICE_BITS'(1);

  sweep_state_t          state;
  logic [VOICE_BITS-1:0] v;
  logic [PHASE_WIDTH-1:0] phase_sum;

  // RAM read data only lands in the WR cycle, so the write-back sum is combinational.
  assign phase_sum = ram_rdata + inc_data;
  assign ram_wdata = (state == ST_WR) ? phase_sum : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      v           <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      inc_addr    <= '0;
      phase_out   <= '0;
      voice_out   <= '0;
      phase_valid <= 1'b0;
      sweep_done  <= 1'b0;
      busy        <= 1'b1;
      busy_voice  <= '0;
      init_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      phase_valid <= 1'b0;
      sweep_done  <= 1'b0;
      case (state)
        // First INIT cycle arms the write strobe; each following cycle zeroes one voice.
        ST_INIT: begin
          if (!ram_we) begin
            ram_we   <= 1'b1;
            ram_addr <= '0;
            v        <= '0;
          end else if (v == LAST_VOICE) begin
            state     <= ST_IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            v         <= '0;
            init_done <= 1'b1;
            busy      <= 1'b0;
          end else begin
            v        <= v + ONE_VOICE;
            ram_addr <= v + ONE_VOICE;
          end
        end
        ST_IDLE: begin
          if (sample_tick) begin
            state      <= ST_RD;
            v          <= '0;
            ram_addr   <= '0;
            inc_addr   <= '0;
            busy       <= 1'b1;
            busy_voice <= '0;
          end
        end
        ST_RD: begin
          if (sample_tick) overrun <= 1'b1;
          state  <= ST_WR;
          ram_we <= 1'b1;
        end
        ST_WR: begin
          if (sample_tick) overrun <= 1'b1;
          ram_we      <= 1'b0;
          phase_out   <= phase_sum;
          voice_out   <= v;
          phase_valid <= 1'b1;
          if (v == LAST_VOICE) begin
            state      <= ST_IDLE;
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            busy_voice <= '0;
            v          <= '0;
            ram_addr   <= '0;
            inc_addr   <= '0;
          end else begin
            state      <= ST_RD;
            v          <= v + ONE_VOICE;
            ram_addr   <= v + ONE_VOICE;
            inc_addr   <= v + ONE_VOICE;
            busy_voice <= v + ONE_VOICE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_phase_sweeper.sv
// Self-checking bench: phase RAM and increment table modelled as dual-port RAMs,
// results compared against a per-voice accumulate-and-wrap reference model.
module tb_voice_phase_sweeper;
  import voice_phase_sweeper_pkg::*;

  localparam int          NV   = int'(NUM_VOICES);
  localparam int unsigned MASK = (32'd1 << PHASE_WIDTH) - 32'd1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sample_tick;
  logic [VOICE_BITS-1:0]  ram_addr;
  logic                   ram_we;
  logic [PHASE_WIDTH-1:0] ram_wdata;
  logic [PHASE_WIDTH-1:0] ram_rdata;
  logic [VOICE_BITS-1:0]  inc_addr;
  logic [PHASE_WIDTH-1:0] inc_data;
  logic [PHASE_WIDTH-1:0] phase_out;
  logic [VOICE_BITS-1:0]  voice_out;
  logic                   phase_valid;
  logic                   sweep_done;
  logic                   busy;
  logic [VOICE_BITS-1:0]  busy_voice;
  logic                   init_done;
  logic                   overrun;

  logic                   pb_we;
  logic [VOICE_BITS-1:0]  pb_addr;
  logic [PHASE_WIDTH-1:0] pb_din;

  logic [PHASE_WIDTH-1:0] phase_mem [NV];
  logic [PHASE_WIDTH-1:0] inc_mem   [NV];
  int unsigned            phase_m   [NV];
  int unsigned            inc_m     [NV];

  typedef struct {
    int cyc;
    int voice;
    int phase;
  } ev_t;

  ev_t ev_q[$];
  int  done_q[$];
  int  done_busy_q[$];
  int  wlog_addr[$];
  int  wlog_data[$];

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  voice_phase_sweeper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .inc_addr    (inc_addr),
    .inc_data    (inc_data),
    .phase_out   (phase_out),
    .voice_out   (voice_out),
    .phase_valid (phase_valid),
    .sweep_done  (sweep_done),
    .busy        (busy),
    .busy_voice  (busy_voice),
    .init_done   (init_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAMs: port A owned by the DUT, port B driven by the bench.
  always @(posedge clk) begin
    if (ram_we === 1'b1) phase_mem[ram_addr] <= ram_wdata;
    if (pb_we === 1'b1) phase_mem[pb_addr] <= pb_din;
    ram_rdata <= phase_mem[ram_addr];
    inc_data  <= inc_mem[inc_addr];
  end

  always @(negedge clk) begin
    if (phase_valid === 1'b1) ev_q.push_back('{cyc, int'(voice_out), int'(phase_out)});
    if (sweep_done === 1'b1) begin
      done_q.push_back(cyc);
      done_busy_q.push_back(int'(busy));
    end
    if (rst_n === 1'b1 && ram_we === 1'b1 && init_done === 1'b0) begin
      wlog_addr.push_back(int'(ram_addr));
      wlog_data.push_back(int'(ram_wdata));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_inc(input int v, input int unsigned val);
    inc_mem[v] = PHASE_WIDTH'(val);
    inc_m[v]   = val & MASK;
  endtask

  task automatic pb_write(input int a, input int unsigned d);
    pb_addr = VOICE_BITS'(a);
    pb_din  = PHASE_WIDTH'(d);
    pb_we   = 1'b1;
    @(negedge clk);
    pb_we = 1'b0;
    phase_m[a] = d & MASK;
  endtask

  task automatic do_tick(output int t);
    t = cyc;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_valid"}, 32'(phase_valid), 32'd0);
    chk({tag, "_done"}, 32'(sweep_done), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_phase_out"}, 32'(phase_out), 32'd0);
  endtask

  task automatic check_ram(input string tag);
    for (int v = 0; v < NV; v++)
      chk($sformatf("%s_ram%0d", tag, v), 32'(phase_mem[v]), phase_m[v]);
  endtask

  // After reset release: bounded wait, then exactly one zero write per voice in order.
  task automatic wait_init(input string tag);
    for (int i = 0; i < 64 && init_done !== 1'b1; i++) @(negedge clk);
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_init_wr_count"}, 32'(wlog_addr.size()), 32'(NV));
    for (int i = 0; i < NV && i < wlog_addr.size(); i++) begin
      chk($sformatf("%s_init_addr%0d", tag, i), 32'(wlog_addr[i]), 32'(i));
      chk($sformatf("%s_init_data%0d", tag, i), 32'(wlog_data[i]), 32'd0);
    end
    wlog_addr.delete();
    wlog_data.delete();
    check_ram(tag);
  endtask

  // Consumes one sweep's results; voice k is due at t+3+2k, done at t+2N+1.
  task automatic check_sweep(input string tag, input int t);
    ev_t e;
    chk({tag, "_ev_count"}, 32'(ev_q.size() >= NV), 32'd1);
    if (ev_q.size() < NV) begin
      ev_q.delete();
      return;
    end
    for (int k = 0; k < NV; k++) begin
      e = ev_q.pop_front();
      phase_m[k] = (phase_m[k] + inc_m[k]) & MASK;
      chk($sformatf("%s_voice%0d", tag, k), 32'(e.voice), 32'(k));
      chk($sformatf("%s_phase%0d", tag, k), 32'(e.phase), phase_m[k]);
      chk($sformatf("%s_cyc%0d", tag, k), 32'(e.cyc), 32'(t + 3 + 2 * k));
    end
    chk({tag, "_done_seen"}, 32'(done_q.size() > 0), 32'd1);
    if (done_q.size() > 0) begin
      chk({tag, "_done_cyc"}, 32'(done_q.pop_front()), 32'(t + 2 * NV + 1));
      chk({tag, "_done_busy"}, 32'(done_busy_q.pop_front()), 32'd0);
    end
  endtask

  task automatic run_sweep(input string tag);
    int t;
    do_tick(t);
    wait_to(t + 2 * NV + 3);
    check_sweep(tag, t);
  endtask

  initial begin
    int t;
    int t2;
    int late;
    int early;

    rst_n = 1'b0;
    sample_tick = 1'b0;
    pb_we = 1'b0;
    pb_addr = '0;
    pb_din = '0;
    for (int v = 0; v < NV; v++) set_inc(v, 0);

    // Reset with garbage in the phase RAM; ticks during INIT must be ignored.
    @(negedge clk);
    for (int v = 0; v < NV; v++) pb_write(v, $urandom);
    check_reset_outputs("rst");
    for (int v = 0; v < NV; v++) phase_m[v] = 0;
    rst_n = 1'b1;
    @(negedge clk);
    sample_tick = 1'b1;
    repeat (3) @(negedge clk);
    sample_tick = 1'b0;
    wait_init("init");
    chk("init_no_valid", 32'(ev_q.size()), 32'd0);
    chk("init_overrun", 32'(overrun), 32'd0);

    // inc[v]=v+1 over three sweeps accumulates n*(v+1).
    for (int v = 0; v < NV; v++) set_inc(v, v + 1);
    for (int n = 1; n <= 3; n++) run_sweep($sformatf("ramp%0d", n));
    for (int v = 0; v < NV; v++)
      chk($sformatf("ramp_mem%0d", v), 32'(phase_mem[v]), 32'(3 * (v + 1)));

    // Wrap through the top of the phase range.
    pb_write(3, 32'hFFFFF0);
    set_inc(3, 32'h20);
    run_sweep("wrap");
    chk("wrap_mem3", 32'(phase_mem[3]), 32'h000010);

    // Random phases and increments, one silent voice.
    for (int v = 0; v < NV; v++) begin
      set_inc(v, $urandom);
      pb_write(v, $urandom);
    end
    set_inc(5, 0);
    run_sweep("rand1");
    run_sweep("rand2");
    check_ram("rand");

    // busy_voice tracks the active voice; port-B write to a later voice lands intact.
    do_tick(t);
    for (int c = t + 1; c <= t + 2 * NV; c++) begin
      wait_to(c);
      pb_we = 1'b0;
      chk($sformatf("bv_busy_c%0d", c - t), 32'(busy), 32'd1);
      chk($sformatf("bv_voice_c%0d", c - t), 32'(busy_voice), 32'((c - t - 1) / 2));
      if (c == t + 10) begin
        pb_addr = VOICE_BITS'(12);
        pb_din  = PHASE_WIDTH'(32'h00ABCDE);
        pb_we   = 1'b1;
        phase_m[12] = 32'h00ABCDE;
      end
    end
    pb_we = 1'b0;
    wait_to(t + 2 * NV + 3);
    chk("bv_idle_voice", 32'(busy_voice), 32'd0);
    check_sweep("bv", t);
    check_ram("bv");

    // Overrun: extra tick mid-sweep is ignored; a tick on the done cycle is accepted.
    do_tick(t);
    wait_to(t + 10);
    chk("ovr_before", 32'(overrun), 32'd0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_to(t + 2 * NV + 1);
    chk("ovr_done_cycle", 32'(sweep_done), 32'd1);
    do_tick(t2);
    wait_to(t2 + 2 * NV + 3);
    check_sweep("ovr_a", t);
    check_sweep("ovr_b", t2);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    check_ram("ovr");

    // Reset mid-sweep aborts, re-zeroes the RAM and clears overrun.
    do_tick(t);
    wait_to(t + 9);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int v = 0; v < NV; v++) phase_m[v] = 0;
    wait_init("reinit");
    late = 0;
    early = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].cyc > t + 9) late++;
      else early++;
    end
    chk("midrst_late_valid", 32'(late), 32'd0);
    chk("midrst_early_valid", 32'(early), 32'd4);
    chk("midrst_no_done", 32'(done_q.size()), 32'd0);
    ev_q.delete();
    done_q.delete();
    done_busy_q.delete();
    for (int v = 0; v < NV; v++) set_inc(v, 1);
    run_sweep("post");
    for (int v = 0; v < NV; v++)
      chk($sformatf("post_mem%0d", v), 32'(phase_mem[v]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
